// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Bundles every non-clock/reset signal of the HI/LO multiply/divide controller.
//
// Pipeline side (EXE stage):
//   req_valid  : EXE holds a HI/LO-class instruction
//   req_op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   req_src1   : rs operand
//   req_src2   : rt operand
//   req_ack    : the EXE instruction leaves the stage this cycle
//   flush      : kill the EXE instruction
//   done       : instruction may leave EXE (es_ready_go)
//   hi, lo     : architectural HI/LO registers
//
// Divider IP side (one signed and one unsigned AXI-stream divider):
//   div_dividend, div_divisor          : operands shared by both IPs
//   sdiv_tvalid / sdiv_tready          : signed IP input handshake
//   sdiv_dout_tvalid / sdiv_dout_tdata : signed IP result {quotient, remainder}
//   udiv_*                             : same for the unsigned IP
//
// Modports: slave  = the controller itself
//           master = the environment (pipeline plus divider IPs)
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        req_ack;
    logic        flush;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] div_dividend;
    logic [31:0] div_divisor;

    logic        sdiv_tvalid;
    logic        sdiv_tready;
    logic        sdiv_dout_tvalid;
    logic [63:0] sdiv_dout_tdata;

    logic        udiv_tvalid;
    logic        udiv_tready;
    logic        udiv_dout_tvalid;
    logic [63:0] udiv_dout_tdata;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, req_ack, flush,
        input  sdiv_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
        input  udiv_tready, udiv_dout_tvalid, udiv_dout_tdata,
        output done, hi, lo, div_dividend, div_divisor,
        output sdiv_tvalid, udiv_tvalid
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, req_ack, flush,
        output sdiv_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
        output udiv_tready, udiv_dout_tvalid, udiv_dout_tdata,
        input  done, hi, lo, div_dividend, div_divisor,
        input  sdiv_tvalid, udiv_tvalid
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// HI/LO unit of a MIPS-style EXE stage. Multiplies and MTHI/MTLO finish in one
// cycle and commit when the instruction leaves EXE. Divides are handed to an
// external signed or unsigned AXI-stream divider IP; the result is held until
// the pipeline acknowledges it, and any division killed by a flush is drained
// so a stale result can never land in HI/LO.
//
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : muldiv_ctrl_if.slave (request, HI/LO and divider IP signals)
// -----------------------------------------------------------------------------
module muldiv_ctrl (
    input  logic           clk,
    input  logic           resetn,
    muldiv_ctrl_if.slave   bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_reg;
    logic        div_signed_reg;     // selects which divider IP is in use
    logic        flush_pending_reg;  // flush seen while the operands were still in flight
    logic        sdiv_tvalid_reg;
    logic        udiv_tvalid_reg;
    logic [31:0] dividend_reg;
    logic [31:0] divisor_reg;
    logic [31:0] quot_reg;
    logic [31:0] rem_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic is_div_op;
    logic div_request;
    assign is_div_op   = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
    assign div_request = bus.req_valid && is_div_op;

    // ------------------------------------------------------------------
    // Single-cycle multiplier. Operands are widened to 64 bits (sign- or
    // zero-extended) so the low 64 bits of the product are exact for both
    // MULT and MULTU.
    // ------------------------------------------------------------------
    logic               mul_signed;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] mul_prod;

    assign mul_signed = (bus.req_op == OP_MULT);
    assign mul_a      = {{32{mul_signed & bus.req_src1[31]}}, bus.req_src1};
    assign mul_b      = {{32{mul_signed & bus.req_src2[31]}}, bus.req_src2};
    assign mul_prod   = mul_a * mul_b;

    // ------------------------------------------------------------------
    // Handshake signals of whichever divider IP the current divide uses.
    // The other IP is never looked at, so its stray results are ignored.
    // ------------------------------------------------------------------
    logic        sel_tready;
    logic        sel_dout_tvalid;
    logic [63:0] sel_dout_tdata;

    assign sel_tready      = div_signed_reg ? bus.sdiv_tready      : bus.udiv_tready;
    assign sel_dout_tvalid = div_signed_reg ? bus.sdiv_dout_tvalid : bus.udiv_dout_tvalid;
    assign sel_dout_tdata  = div_signed_reg ? bus.sdiv_dout_tdata  : bus.udiv_dout_tdata;

    // ------------------------------------------------------------------
    // done (es_ready_go) has to be combinational in IDLE: a one-cycle op is
    // ready in the very cycle it is presented, while a divide must hold the
    // stage until its result is available.
    // ------------------------------------------------------------------
    assign bus.done = ((state_reg == ST_IDLE) && !div_request) ||
                      (state_reg == ST_DONE);

    assign bus.hi           = hi_reg;
    assign bus.lo           = lo_reg;
    assign bus.div_dividend = dividend_reg;
    assign bus.div_divisor  = divisor_reg;
    assign bus.sdiv_tvalid  = sdiv_tvalid_reg;
    assign bus.udiv_tvalid  = udiv_tvalid_reg;

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= ST_IDLE;
            div_signed_reg    <= 1'b0;
            flush_pending_reg <= 1'b0;
            sdiv_tvalid_reg   <= 1'b0;
            udiv_tvalid_reg   <= 1'b0;
            dividend_reg      <= 32'd0;
            divisor_reg       <= 32'd0;
            quot_reg          <= 32'd0;
            rem_reg           <= 32'd0;
            hi_reg            <= 32'd0;
            lo_reg            <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        if (is_div_op) begin
                            // Operands are captured here so they stay stable
                            // for the IP regardless of what EXE does next.
                            dividend_reg      <= bus.req_src1;
                            divisor_reg       <= bus.req_src2;
                            div_signed_reg    <= (bus.req_op == OP_DIV);
                            sdiv_tvalid_reg   <= (bus.req_op == OP_DIV);
                            udiv_tvalid_reg   <= (bus.req_op == OP_DIVU);
                            flush_pending_reg <= 1'b0;
                            state_reg         <= ST_SEND;
                        end else if (bus.req_ack) begin
                            case (bus.req_op)
                                OP_MULT, OP_MULTU: begin
                                    hi_reg <= mul_prod[63:32];
                                    lo_reg <= mul_prod[31:0];
                                end
                                OP_MTHI: hi_reg <= bus.req_src1;
                                OP_MTLO: lo_reg <= bus.req_src1;
                                default: ;  // no-op writes nothing
                            endcase
                        end
                    end
                end

                ST_SEND: begin
                    // An AXI-stream source may not withdraw tvalid, so a flush
                    // is only remembered here and acted on after the handshake.
                    if (bus.flush) begin
                        flush_pending_reg <= 1'b1;
                    end
                    if (sel_tready) begin
                        sdiv_tvalid_reg <= 1'b0;
                        udiv_tvalid_reg <= 1'b0;
                        state_reg       <= (bus.flush || flush_pending_reg) ? ST_DRAIN : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.flush) begin
                        // A result arriving together with the flush is already
                        // consumed, so there is nothing left to drain.
                        state_reg <= sel_dout_tvalid ? ST_IDLE : ST_DRAIN;
                    end else if (sel_dout_tvalid) begin
                        quot_reg  <= sel_dout_tdata[63:32];
                        rem_reg   <= sel_dout_tdata[31:0];
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Flush wins over req_ack: a killed divide never commits.
                    if (bus.flush) begin
                        state_reg <= ST_IDLE;
                    end else if (bus.req_ack) begin
                        lo_reg    <= quot_reg;
                        hi_reg    <= rem_reg;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_DRAIN: begin
                    // Swallow the result of the killed divide before accepting
                    // new work, so it cannot be mistaken for a later one.
                    if (sel_dout_tvalid) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic clk;
    logic resetn;

    muldiv_ctrl_if ifc ();

    muldiv_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model of the architectural HI/LO registers
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    task automatic idle_inputs();
        ifc.req_valid        = 1'b0;
        ifc.req_op           = 3'd6;
        ifc.req_src1         = 32'd0;
        ifc.req_src2         = 32'd0;
        ifc.req_ack          = 1'b0;
        ifc.flush            = 1'b0;
        ifc.sdiv_tready      = 1'b0;
        ifc.sdiv_dout_tvalid = 1'b0;
        ifc.sdiv_dout_tdata  = 64'd0;
        ifc.udiv_tready      = 1'b0;
        ifc.udiv_dout_tvalid = 1'b0;
        ifc.udiv_dout_tdata  = 64'd0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] v;
        @(negedge clk);
        #1;
        total++; if (ifc.hi !== 32'd0) begin bad++; $display("FAIL rst_hi got=%h exp=%h", ifc.hi, 32'd0); end
        total++; if (ifc.lo !== 32'd0) begin bad++; $display("FAIL rst_lo got=%h exp=%h", ifc.lo, 32'd0); end
        total++; if ({ifc.sdiv_tvalid, ifc.udiv_tvalid} !== 2'b00) begin bad++; $display("FAIL rst_tvalid got=%b exp=00", {ifc.sdiv_tvalid, ifc.udiv_tvalid}); end
        total++; if ({ifc.div_dividend, ifc.div_divisor} !== 64'd0) begin bad++; $display("FAIL rst_operands got=%h exp=0", {ifc.div_dividend, ifc.div_divisor}); end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        // First request right after release must be taken on the first edge
        @(negedge clk);
        v = $urandom();
        resetn        = 1'b1;
        ifc.req_valid = 1'b1;
        ifc.req_op    = 3'd4;
        ifc.req_src1  = v;
        ifc.req_ack   = 1'b1;
        #1;
        total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL rst_first_done got=%b exp=1", ifc.done); end
        @(negedge clk);
        idle_inputs();
        exp_hi = v;
        #1;
        total++; if (ifc.hi !== exp_hi) begin bad++; $display("FAIL rst_first_mthi got=%h exp=%h", ifc.hi, exp_hi); end
        $display("reset: first MTHI %h -> hi=%h lo=%h", v, ifc.hi, ifc.lo);
    endtask

    // ------------------------------------------------------------------
    task automatic test_mult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        logic [63:0] p;
        if (op == 3'd0) p = longint'(int'(a)) * longint'(int'(b));
        else            p = {32'd0, a} * {32'd0, b};
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_src1  = a;
        ifc.req_src2  = b;
        ifc.req_ack   = 1'b1;
        ifc.flush     = fl;
        #1;
        total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL mult_done got=%b exp=1", ifc.done); end
        total++; if (ifc.hi !== exp_hi || ifc.lo !== exp_lo) begin bad++; $display("FAIL mult_no_bypass got=%h_%h exp=%h_%h", ifc.hi, ifc.lo, exp_hi, exp_lo); end
        @(negedge clk);
        idle_inputs();
        if (!fl) begin
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end
        #1;
        total++; if (ifc.hi !== exp_hi) begin bad++; $display("FAIL mult_hi got=%h exp=%h", ifc.hi, exp_hi); end
        total++; if (ifc.lo !== exp_lo) begin bad++; $display("FAIL mult_lo got=%h exp=%h", ifc.lo, exp_lo); end
        $display("mult op=%0d a=%h b=%h flush=%0b -> hi=%h lo=%h", op, a, b, fl, ifc.hi, ifc.lo);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_move(input logic [2:0] op, input logic [31:0] v, input logic fl);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_src1  = v;
        ifc.req_src2  = $urandom();
        ifc.req_ack   = 1'b1;
        ifc.flush     = fl;
        #1;
        total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL move_done got=%b exp=1", ifc.done); end
        @(negedge clk);
        idle_inputs();
        if (!fl && op == 3'd4) exp_hi = v;
        if (!fl && op == 3'd5) exp_lo = v;
        #1;
        total++; if (ifc.hi !== exp_hi) begin bad++; $display("FAIL move_hi got=%h exp=%h", ifc.hi, exp_hi); end
        total++; if (ifc.lo !== exp_lo) begin bad++; $display("FAIL move_lo got=%h exp=%h", ifc.lo, exp_lo); end
        $display("move op=%0d v=%h flush=%0b -> hi=%h lo=%h", op, v, fl, ifc.hi, ifc.lo);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // One divide transaction driven cycle by cycle, playing both the pipeline
    // and the divider IP. mode: 0 normal, 1 flush in SEND, 2 flush in WAIT,
    // 3 flush together with dout, 4 flush (with ack) in DONE.
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int rdy_dly, input int lat, input int stall, input int mode);
        logic        sel_s;
        logic [31:0] q, r, hi0, lo0;
        logic        sel_tv, oth_tv;
        int          sa, sb, done_cnt;
        sel_s = (op == 3'd2);
        if (sel_s) begin
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        hi0 = exp_hi;
        lo0 = exp_lo;
        done_cnt = 0;

        // IDLE: request presented, stage must be held
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_src1  = a;
        ifc.req_src2  = b;
        ifc.req_ack   = 1'b0;
        ifc.flush     = 1'b0;
        #1;
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL div_idle_done got=%b exp=0", ifc.done); end
        @(negedge clk);

        // SEND: selected tvalid until tready; the other IP is always ready
        for (int i = 0; i <= rdy_dly; i++) begin
            ifc.sdiv_tready = sel_s ? (i == rdy_dly) : 1'b1;
            ifc.udiv_tready = sel_s ? 1'b1 : (i == rdy_dly);
            ifc.flush       = (mode == 1 && i == 0);
            ifc.req_src1    = $urandom();
            ifc.req_src2    = $urandom();
            #1;
            sel_tv = sel_s ? ifc.sdiv_tvalid : ifc.udiv_tvalid;
            oth_tv = sel_s ? ifc.udiv_tvalid : ifc.sdiv_tvalid;
            total++; if (sel_tv !== 1'b1) begin bad++; $display("FAIL send_tvalid cyc=%0d got=%b exp=1", i, sel_tv); end
            total++; if (oth_tv !== 1'b0) begin bad++; $display("FAIL send_other_tvalid cyc=%0d got=%b exp=0", i, oth_tv); end
            total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL send_done cyc=%0d got=%b exp=0", i, ifc.done); end
            total++; if (ifc.div_dividend !== a || ifc.div_divisor !== b) begin bad++; $display("FAIL send_operands got=%h/%h exp=%h/%h", ifc.div_dividend, ifc.div_divisor, a, b); end
            @(negedge clk);
        end
        ifc.sdiv_tready = 1'b0;
        ifc.udiv_tready = 1'b0;
        ifc.flush       = 1'b0;

        // WAIT / DRAIN: result after lat cycles; other IP emits garbage meanwhile
        for (int j = 1; j <= lat; j++) begin
            ifc.sdiv_dout_tvalid = sel_s ? (j == lat) : (j < lat);
            ifc.udiv_dout_tvalid = sel_s ? (j < lat) : (j == lat);
            ifc.sdiv_dout_tdata  = sel_s ? {q, r} : 64'hDEADBEEF_0BADF00D;
            ifc.udiv_dout_tdata  = sel_s ? 64'hDEADBEEF_0BADF00D : {q, r};
            ifc.flush            = (mode == 2 && j == 1) || (mode == 3 && j == lat);
            #1;
            total++; if ({ifc.sdiv_tvalid, ifc.udiv_tvalid} !== 2'b00) begin bad++; $display("FAIL wait_tvalid cyc=%0d got=%b exp=00", j, {ifc.sdiv_tvalid, ifc.udiv_tvalid}); end
            total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL wait_done cyc=%0d got=%b exp=0", j, ifc.done); end
            total++; if (ifc.hi !== hi0 || ifc.lo !== lo0) begin bad++; $display("FAIL wait_hilo got=%h_%h exp=%h_%h", ifc.hi, ifc.lo, hi0, lo0); end
            @(negedge clk);
        end
        ifc.sdiv_dout_tvalid = 1'b0;
        ifc.udiv_dout_tvalid = 1'b0;
        ifc.flush            = 1'b0;

        // DONE: EXE may stall; a stray result in the first cycle is ignored
        if (mode == 0 || mode == 4) begin
            for (int k = 0; k <= stall; k++) begin
                ifc.req_ack = (k == stall);
                ifc.flush   = (mode == 4 && k == stall);
                if (sel_s) begin
                    ifc.sdiv_dout_tvalid = (k == 0);
                    ifc.sdiv_dout_tdata  = {~q, ~r};
                end else begin
                    ifc.udiv_dout_tvalid = (k == 0);
                    ifc.udiv_dout_tdata  = {~q, ~r};
                end
                #1;
                if (ifc.done === 1'b1) done_cnt++;
                total++; if (ifc.hi !== hi0 || ifc.lo !== lo0) begin bad++; $display("FAIL done_no_bypass got=%h_%h exp=%h_%h", ifc.hi, ifc.lo, hi0, lo0); end
                @(negedge clk);
            end
            total++; if (done_cnt != stall + 1) begin bad++; $display("FAIL done_cycles got=%0d exp=%0d", done_cnt, stall + 1); end
        end
        idle_inputs();
        if (mode == 0) begin
            exp_lo = q;
            exp_hi = r;
        end

        // Back in IDLE: a no-op with ack is ready at once and writes nothing
        ifc.req_valid = 1'b1;
        ifc.req_op    = 3'd6;
        ifc.req_ack   = 1'b1;
        #1;
        total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL div_back_idle got=%b exp=1", ifc.done); end
        total++; if (ifc.hi !== exp_hi) begin bad++; $display("FAIL div_hi got=%h exp=%h", ifc.hi, exp_hi); end
        total++; if (ifc.lo !== exp_lo) begin bad++; $display("FAIL div_lo got=%h exp=%h", ifc.lo, exp_lo); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (ifc.hi !== exp_hi || ifc.lo !== exp_lo) begin bad++; $display("FAIL div_single_write got=%h_%h exp=%h_%h", ifc.hi, ifc.lo, exp_hi, exp_lo); end
        $display("div op=%0d a=%h b=%h rdy=%0d lat=%0d stall=%0d mode=%0d -> hi=%h lo=%h",
                 op, a, b, rdy_dly, lat, stall, mode, ifc.hi, ifc.lo);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush_idle();
        ifc.req_valid = 1'b1;
        ifc.req_op    = 3'd2;
        ifc.req_src1  = 32'd40;
        ifc.req_src2  = 32'd4;
        ifc.req_ack   = 1'b1;
        ifc.flush     = 1'b1;
        #1;
        @(negedge clk);
        idle_inputs();
        ifc.req_valid = 1'b1;
        ifc.req_op    = 3'd7;
        #1;
        total++; if ({ifc.sdiv_tvalid, ifc.udiv_tvalid} !== 2'b00) begin bad++; $display("FAIL flush_idle_tvalid got=%b exp=00", {ifc.sdiv_tvalid, ifc.udiv_tvalid}); end
        total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL flush_idle_done got=%b exp=1", ifc.done); end
        total++; if (ifc.hi !== exp_hi || ifc.lo !== exp_lo) begin bad++; $display("FAIL flush_idle_hilo got=%h_%h exp=%h_%h", ifc.hi, ifc.lo, exp_hi, exp_lo); end
        $display("flush idle DIV 40/4 -> hi=%h lo=%h", ifc.hi, ifc.lo);
        @(negedge clk);
        idle_inputs();
        test_mult(3'd0, 32'h0000_1234, 32'h0000_5678, 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_div();
        test_move(3'd4, 32'hAAAA5555, 1'b0);
        test_move(3'd5, 32'h5555AAAA, 1'b0);
        ifc.req_valid = 1'b1;
        ifc.req_op    = 3'd3;
        ifc.req_src1  = 32'd50;
        ifc.req_src2  = 32'd5;
        #1;
        @(negedge clk);
        ifc.udiv_tready = 1'b1;
        #1;
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        total++; if (ifc.hi !== 32'd0 || ifc.lo !== 32'd0) begin bad++; $display("FAIL midrst_hilo got=%h_%h exp=0_0", ifc.hi, ifc.lo); end
        total++; if ({ifc.div_dividend, ifc.div_divisor} !== 64'd0) begin bad++; $display("FAIL midrst_operands got=%h exp=0", {ifc.div_dividend, ifc.div_divisor}); end
        total++; if ({ifc.sdiv_tvalid, ifc.udiv_tvalid} !== 2'b00) begin bad++; $display("FAIL midrst_tvalid got=%b exp=00", {ifc.sdiv_tvalid, ifc.udiv_tvalid}); end
        @(negedge clk);
        resetn = 1'b1;
        ifc.udiv_dout_tvalid = 1'b1;
        ifc.udiv_dout_tdata  = {32'd10, 32'd0};
        #1;
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (ifc.hi !== 32'd0 || ifc.lo !== 32'd0) begin bad++; $display("FAIL midrst_stray got=%h_%h exp=0_0", ifc.hi, ifc.lo); end
        $display("reset mid-divide -> hi=%h lo=%h", ifc.hi, ifc.lo);
        @(negedge clk);
        run_div(3'd3, 32'd9, 32'd3, 0, 1, 0, 0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_div(input int n);
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat, mode;
        for (int t = 0; t < n; t++) begin
            op = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
            a  = $urandom();
            b  = $urandom();
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(16, 30);
            if (b == 32'd0) b = 32'd1;
            if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            mode = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            lat  = $urandom_range(1, 4);
            if (mode == 2 && lat < 2) lat = 2;
            run_div(op, a, b, $urandom_range(0, 3), lat, $urandom_range(0, 2), mode);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        resetn = 1'b0;
        idle_inputs();
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        test_reset();

        test_mult(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        total++; if (exp_hi !== 32'hFFFF_FFFF || ifc.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_directed got=%h_%h exp=ffffffff_fffffffa", ifc.hi, ifc.lo); end
        test_mult(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        total++; if (ifc.hi !== 32'h0000_0002 || ifc.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_directed got=%h_%h exp=00000002_fffffffa", ifc.hi, ifc.lo); end
        for (int t = 0; t < 16; t++) begin
            test_mult(3'($urandom_range(0, 1)), $urandom(), $urandom(), ($urandom_range(0, 5) == 0));
        end

        for (int t = 0; t < 10; t++) begin
            test_move(3'($urandom_range(4, 7)), $urandom(), ($urandom_range(0, 3) == 0));
        end

        // Signed divide, tready two cycles late, result five cycles later
        run_div(3'd2, 32'hFFFF_FFF9, 32'd2, 2, 5, 0, 0);
        total++; if (ifc.lo !== 32'hFFFF_FFFD || ifc.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_directed got=%h_%h exp=ffffffff_fffffffd", ifc.hi, ifc.lo); end

        // Flush while waiting for the result, then an MTHI must still work
        run_div(3'd3, 32'd100, 32'd7, 0, 3, 0, 2);
        test_move(3'd4, 32'h0000_1234, 1'b0);

        // Flush while tready is held low, flush together with dout, flush in DONE
        run_div(3'd2, 32'd1000, 32'hFFFF_FFFD, 2, 2, 0, 1);
        run_div(3'd3, 32'd77, 32'd5, 1, 2, 0, 3);
        run_div(3'd2, 32'd63, 32'd8, 0, 1, 1, 4);

        // EXE stalls three cycles in DONE
        run_div(3'd3, 32'd123456, 32'd789, 1, 2, 3, 0);

        test_flush_idle();
        test_reset_mid_div();
        test_random_div(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock; resetn in 1, asynchronous active-low reset.
REQ-002 SHALL have req_valid in 1, EXE holds a HI/LO-class instruction; req_op in 3, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-003 SHALL have req_src1 in 32 (rs) and req_src2 in 32 (rt).
REQ-004 SHALL have req_ack in 1, the EXE instruction leaves the stage this cycle; flush in 1, kill the EXE instruction.
REQ-005 SHALL have done out 1, usable as es_ready_go; hi out 32 and lo out 32, architectural HI/LO.
REQ-006 SHALL have div_dividend out 32 and div_divisor out 32, operands shared by both divider IPs.
REQ-007 SHALL have sdiv_tvalid out 1 (dividend and divisor tvalid of the signed IP), sdiv_tready in 1 (AND of both treadys), sdiv_dout_tvalid in 1, and sdiv_dout_tdata in 64.
REQ-008 SHALL have udiv_tvalid, udiv_tready, udiv_dout_tvalid and udiv_dout_tdata, with the same meanings for the unsigned IP.

Function
REQ-009 SHALL implement the FSM states IDLE, SEND, WAIT, DONE and DRAIN.
REQ-010 IDLE with req_valid, !flush and op DIV/DIVU: SHALL capture src1 into div_dividend and src2 into div_divisor, latch signedness, and go to SEND.
REQ-011 IDLE with req_valid and op MULT/MTHI/MTLO/no-op: done=1 combinationally in the same cycle.
REQ-012 For MULT/MULTU, on req_ack & !flush: HI<=prod[63:32], LO<=prod[31:0]; MULT uses a signed 32x32 product, MULTU an unsigned one.
REQ-013 On req_ack & !flush: MTHI writes HI<=src1 only; MTLO writes LO<=src1 only; no-op writes nothing.
REQ-014 SEND: the selected tvalid=1, held until a cycle with its tready=1, then go to WAIT; the other IP's tvalid stays 0.
REQ-015 SEND operands SHALL remain stable until the handshake completes.
REQ-016 WAIT: tvalid=0; on the selected dout_tvalid, capture quotient=tdata[63:32] and remainder=tdata[31:0] into internal regs and go to DONE.
REQ-017 DONE: done=1; on req_ack, LO<=quotient and HI<=remainder, then go to IDLE.
REQ-018 done SHALL be 0 in SEND, WAIT and DRAIN, and 0 in IDLE when a DIV/DIVU request is present.
REQ-019 Minimum DIV latency SHALL be 1 SEND cycle, plus the IP latency, plus 1 DONE cycle.
REQ-020 Flush in IDLE: the request is ignored, with no HI/LO write.
REQ-021 Flush in SEND: tvalid is held until its handshake completes (no tvalid withdrawal), then go to DRAIN, even if flush has since deasserted.
REQ-022 Flush in WAIT: go to DRAIN. If dout_tvalid arrives in the same cycle, discard it and go to IDLE.
REQ-023 Flush in DONE: discard the result and go to IDLE; HI/LO unchanged. Flush has priority over req_ack.
REQ-024 DRAIN: on the selected dout_tvalid, discard the result and go to IDLE; new requests are not accepted and done=0.
REQ-025 dout_tvalid from either IP in IDLE or DONE SHALL be ignored.
REQ-026 HI/LO SHALL be written only via REQ-012/013/017, and never more than once per instruction.
REQ-027 hi/lo SHALL be direct register outputs, with no bypass of the pending write.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, sdiv_tvalid=udiv_tvalid=0, hi=lo=0, div_dividend=div_divisor=0, and internal quotient/remainder=0.
REQ-029 Reset mid-division SHALL return to IDLE; a late dout_tvalid from the IP is ignored per REQ-025.
REQ-030 After resetn rises, the first request SHALL be accepted in the first clk edge.

Verification
REQ-031 MULT with src1=0xFFFFFFFE, src2=3, req_ack=1 -> done=1 same cycle; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-032 DIV src1=-7, src2=2; IP tready delayed 2 cycles, dout after 5 cycles -> sdiv_tvalid high 3 cycles, done rises one cycle after dout; after req_ack lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU 100/7 with flush in WAIT -> DRAIN; dout absorbed, hi/lo unchanged; a following MTHI 0x1234 completes with hi=0x1234.
REQ-034 Flush in SEND with tready low for 2 cycles -> tvalid stays high until tready, then DRAIN; done stays 0 throughout; hi/lo unchanged.
REQ-035 DONE with req_ack=0 for 3 cycles (EXE stall), then req_ack -> done held high 4 cycles; exactly one HI/LO write.
REQ-036 resetn pulsed low during WAIT -> outputs cleared; the stray dout_tvalid afterward causes no HI/LO change; a subsequent DIVU 9/3 yields lo=3, hi=0.
